// File: rtl/bus_master_ctrl.sv
// Initiator end of the valid/ready bus: one command in flight, slave ready pulse
// or watchdog timeout terminates it, and the result is returned on a response port.
module bus_master_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,

    output logic              bus_valid,
    output logic              bus_wr_en,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    input  logic [1:0]        bus_resp
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [1:0] RESP_TIMEOUT = 2'b11;
    localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT - 1);

    state_t              state, state_d;
    logic [7:0]          cnt, cnt_d;
    logic                cmd_ready_d;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic [1:0]          rsp_resp_d;
    logic                bus_valid_d;
    logic                bus_wr_en_d;
    logic [ADDR_W-1:0]   bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_d;

    // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;
        bus_valid_d = bus_valid;
        bus_wr_en_d = bus_wr_en;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;

        case (state)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    bus_wr_en_d = cmd_wr;
                    bus_addr_d  = cmd_addr;
                    bus_wdata_d = cmd_wdata;
                    bus_valid_d = 1'b1;
                    cmd_ready_d = 1'b0;
                    cnt_d       = 8'd0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // A ready pulse on the timeout edge still completes normally.
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    rsp_rdata_d = bus_wr_en ? '0 : bus_rdata;
                    rsp_resp_d  = bus_resp;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt == CNT_LAST) begin
                    bus_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_TIMEOUT;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            RESP: begin
                // Bus stays idle here, giving the slave a low cycle between requests.
                bus_valid_d = 1'b0;
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            bus_valid <= 1'b0;
            bus_wr_en <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_resp  <= rsp_resp_d;
            bus_valid <= bus_valid_d;
            bus_wr_en <= bus_wr_en_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Scoreboard bench for bus_master_ctrl: a memory slave model at 0x00-0x7F,
// expected responses queued at issue time and checked by a response monitor.
module tb_bus_master_ctrl;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              bus_valid;
    logic              bus_wr_en;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;
    logic [1:0]        bus_resp;

    bus_master_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_resp (rsp_resp),
        .bus_valid(bus_valid),
        .bus_wr_en(bus_wr_en),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready),
        .bus_resp (bus_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic [1:0]        resp;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: answers mapped addresses after slave_lat extra cycles.
    logic [DATA_W-1:0] mem [0:127];
    int                slave_lat  = 1;
    logic [1:0]        slave_resp = 2'b00;
    int                stray_req  = 0;

    initial begin
        int  wcnt;
        int  stray_seen;
        bit  served;
        bus_ready  = 1'b0;
        bus_rdata  = '0;
        bus_resp   = 2'b00;
        wcnt       = 0;
        stray_seen = 0;
        served     = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            bus_ready = 1'b0;
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                bus_ready  = 1'b1;
                bus_resp   = 2'b00;
                bus_rdata  = 32'hBAD0_BAD0;
            end else if (bus_valid && !bus_addr[7] && !served) begin
                if (wcnt >= slave_lat) begin
                    bus_ready = 1'b1;
                    bus_resp  = slave_resp;
                    served    = 1'b1;
                    if (bus_wr_en) begin
                        mem[bus_addr[6:0]] = bus_wdata;
                        bus_rdata          = 32'hFFFF_0000;
                    end else begin
                        bus_rdata = mem[bus_addr[6:0]];
                    end
                end else begin
                    wcnt++;
                end
            end else if (!bus_valid) begin
                wcnt   = 0;
                served = 1'b0;
            end
        end
    end

    // Bus monitor: pulse lengths, pulse count, field stability within a pulse.
    int                cur_len = 0;
    int                last_len = 0;
    int                n_pulses = 0;
    bit                bus_unstable = 1'b0;
    logic              cap_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus_valid) begin
                if (cur_len == 0) begin
                    cap_wr    = bus_wr_en;
                    cap_addr  = bus_addr;
                    cap_wdata = bus_wdata;
                end else if (bus_wr_en !== cap_wr || bus_addr !== cap_addr || bus_wdata !== cap_wdata) begin
                    bus_unstable = 1'b1;
                end
                cur_len++;
            end else if (cur_len != 0) begin
                last_len = cur_len;
                cur_len  = 0;
                n_pulses++;
            end
        end
    end

    // Response monitor: every handshake pops one expected entry.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the command is accepted.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input logic [DATA_W-1:0] exp_rdata, input logic [1:0] exp_resp);
        rsp_t e;
        int   n;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        e.rdata   = exp_rdata;
        e.resp    = exp_resp;
        exp_q.push_back(e);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_drain", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] wdat [0:3];

    initial begin
        int n;
        int p0;
        wdat[0] = 32'hA5A5_0001;
        wdat[1] = 32'h1234_5678;
        wdat[2] = 32'hCAFE_F00D;
        wdat[3] = 32'h0F0F_F0F0;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_wr_en", 32'(bus_wr_en), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Write then read
        slave_lat = 1;
        issue(1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, 2'b00);
        cmd_valid = 1'b0;
        wait_drain();
        check("wr_pulse_len_2to4", 32'(last_len >= 2 && last_len <= 4), 32'd1);
        slave_lat = 2;
        issue(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 2'b00);
        cmd_valid = 1'b0;
        wait_drain();
        check("rd_pulse_len_2to4", 32'(last_len >= 2 && last_len <= 4), 32'd1);

        // Slave error response passes through
        slave_lat  = 1;
        slave_resp = 2'b10;
        issue(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 2'b10);
        cmd_valid = 1'b0;
        wait_drain();
        slave_resp = 2'b00;

        // Unmapped address times out, then a stray ready is ignored
        issue(1'b0, 8'h80, 32'h0, 32'h0, 2'b11);
        cmd_valid = 1'b0;
        wait_drain();
        check("timeout_pulse_len", 32'(last_len), 32'd16);
        stray_req++;
        repeat (3) @(negedge clk);
        check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        check("stray_bus_valid", 32'(bus_valid), 32'd0);
        check("stray_cmd_ready", 32'(cmd_ready), 32'd1);

        // Response backpressure
        rsp_ready = 1'b0;
        issue(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 2'b00);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            check("bp_rdata_stable", rsp_rdata, 32'hDEAD_BEEF);
            check("bp_resp_stable", 32'(rsp_resp), 32'd0);
            check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
            check("bp_bus_valid_low", 32'(bus_valid), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        check("bp_rsp_valid_clear", 32'(rsp_valid), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back writes with cmd_valid held, then readback
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) issue(1'b1, 8'(i), wdat[i], 32'h0, 2'b00);
        cmd_valid = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
        check("b2b_pulse_count", 32'(n_pulses - p0), 32'd4);
        for (int i = 0; i < 4; i++) issue(1'b0, 8'(i), 32'h0, wdat[i], 2'b00);
        cmd_valid = 1'b0;
        wait_drain();

        // Reset while BUSY drops the transaction
        slave_lat = 10;
        issue(1'b0, 8'h01, 32'h0, wdat[1], 2'b00);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_rst", 32'(bus_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_bus_valid", 32'(bus_valid), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (12) @(negedge clk);
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        slave_lat = 1;
        issue(1'b0, 8'h01, 32'h0, wdat[1], 2'b00);
        cmd_valid = 1'b0;
        wait_drain();

        // Ready coincident with the timeout edge
        slave_lat = 15;
        issue(1'b0, 8'h02, 32'h0, wdat[2], 2'b00);
        cmd_valid = 1'b0;
        wait_drain();
        check("coincide_pulse_len", 32'(last_len), 32'd16);
        slave_lat = 1;

        repeat (3) @(negedge clk);
        check("bus_fields_stable", 32'(bus_unstable), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/bus_master_ctrl.md
Name: bus_master_ctrl

Overview:
- Initiator end of the simple valid/ready bus.
- Accepts single-beat read/write commands on a local valid/ready command port and drives one bus transaction at a time toward the slaves.
- Waits for the slave's one-cycle ready pulse, captures rdata/resp, and returns a response on a local valid/ready response port.
- A watchdog terminates transactions to unmapped addresses with a timeout response; the block sits between test/CPU-side traffic generators and the shared bus.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT, 16, bus cycles with valid high and no ready before abort; legal range 2..255.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at posedge.
- cmd_wr  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid&rsp_ready at posedge.
- rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts.
- rsp_resp  output  2  00=OKAY (RESP_OKAY), slave resp passed through, 11=TIMEOUT.
- bus_valid  output  1  bus request.
- bus_wr_en  output  1  bus write enable.
- bus_addr  output  ADDR_W  bus address.
- bus_wdata  output  DATA_W  bus write data.
- bus_rdata  input  DATA_W  slave read data.
- bus_ready  input  1  slave completion pulse (one cycle).
- bus_resp  input  2  slave response.

Behaviour:
- Reset (async, immediate): state=IDLE; cmd_ready=0; rsp_valid=0; rsp_rdata=0; rsp_resp=0; bus_valid=0; bus_wr_en=0; bus_addr=0; bus_wdata=0; timeout counter=0. An in-flight transaction is dropped and no response is produced.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1 (registered, asserted the cycle after reset release).
  - On cmd_valid&cmd_ready: register cmd_wr/addr/wdata onto bus_wr_en/bus_addr/bus_wdata, set bus_valid=1, cmd_ready=0, counter=0, go to BUSY.
- BUSY:
  - bus_valid and bus fields held stable.
  - Each posedge with bus_ready=1: bus_valid<=0; rsp_rdata<=wr?0:bus_rdata; rsp_resp<=bus_resp; rsp_valid<=1; go to RESP.
  - Else if counter==TIMEOUT-1: bus_valid<=0; rsp_rdata<=0; rsp_resp<=2'b11; rsp_valid<=1; go to RESP.
  - Else counter++.
- RESP:
  - bus_valid=0. This guarantees at least one idle bus cycle between transactions, so a slave never re-samples a completed request.
  - rsp_* held stable until rsp_valid&rsp_ready. Then rsp_valid<=0, cmd_ready<=1, go to IDLE.
- Latency: command accept edge E0 -> bus_valid high after E0. The slave's ready is sampled at edge Ek -> rsp_valid high after Ek.
- Minimum command-to-command spacing: 3 cycles (IDLE, BUSY, RESP).
- bus_ready while not in BUSY (late pulse after timeout) is ignored; no state change.
- bus_ready and timeout on the same edge: ready wins, normal response.
- cmd_valid while cmd_ready=0: command is held by the source; nothing is latched.
- Counter width: 8 bits, no wrap possible given the TIMEOUT range.

Test Plan:
- Write then read, slave at base 0x00: cmd write addr 0x10 data 0xDEADBEEF -> bus_valid high until ready, rsp_resp=00, rsp_rdata=0. Then read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_resp=00. Each bus_valid pulse spans 2-4 cycles.
- Unmapped address 0x80, no slave responds -> bus_valid high exactly 16 cycles, then rsp_valid with rsp_resp=11, rsp_rdata=0; a later stray bus_ready has no effect.
- Response backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_rdata/rsp_resp stable, cmd_ready stays 0, bus_valid stays 0. Then rsp_ready=1 -> cmd_ready=1 next cycle.
- Back-to-back: cmd_valid held high with 4 writes to 0x00-0x03 -> 4 responses in order, bus_valid low at least 1 cycle between requests, memory contents correct on readback.
- Reset mid-transaction: assert rst while in BUSY -> bus_valid, rsp_valid, cmd_ready all 0 immediately. After release: no response emitted, cmd_ready=1, and the next read completes normally.
- Ready coincident with timeout: force bus_ready on the 16th cycle -> rsp_resp equals bus_resp (00), not 11.
